// File: rtl/id_fetch_return_pkg.sv
// Shared opcode and instruction-field constants for the decode-side fetch partner.
package id_fetch_return_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Which register-file read ports an opcode actually consumes.
  function automatic logic uses_rs(input logic [5:0] op);
    return op != OP_J;
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ);
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// Combinational stall decision for the instruction in ID: load-use plus beq operand hazards.
module hazard_detect
  import id_fetch_return_pkg::*;
(
  input  logic       id_valid,
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_rd,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_rd,
  output logic       stall
);
  logic is_beq;
  logic load_use;
  logic branch_ex;
  logic branch_mem;

  assign is_beq = (op == OP_BEQ);

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((uses_rs(op) && (ex_rd == rs)) || (uses_rt(op) && (ex_rd == rt)));

  // beq compares in ID, so it must also wait out ALU results in EX and loads still in MEM.
  assign branch_ex  = is_beq && ex_reg_write && (ex_rd != 5'd0) &&
                      ((ex_rd == rs) || (ex_rd == rt));
  assign branch_mem = is_beq && mem_mem_read && (mem_rd != 5'd0) &&
                      ((mem_rd == rs) || (mem_rd == rt));

  assign stall = id_valid && (load_use || branch_ex || branch_mem);
endmodule

// File: rtl/id_fetch_return.sv
// IF/ID pipeline register with in-ID beq/j resolution, redirect outputs and hazard stalls.
module id_fetch_return
  import id_fetch_return_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc_plus4,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [4:0]        ex_rd,
  input  logic              mem_mem_read,
  input  logic [4:0]        mem_rd,
  output logic              pc_en,
  output logic              branch_taken,
  output logic [ADDR_W-1:0] branch_address,
  output logic              jump,
  output logic [ADDR_W-1:0] jump_address,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic              id_valid,
  output logic              id_bubble
);
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic        stall;

  assign op  = id_instr[OP_HI:OP_LO];
  assign rs  = id_instr[RS_HI:RS_LO];
  assign rt  = id_instr[RT_HI:RT_LO];
  assign imm = id_instr[IMM_HI:IMM_LO];

  hazard_detect u_hazard (
    .id_valid     (id_valid),
    .op           (op),
    .rs           (rs),
    .rt           (rt),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .mem_mem_read (mem_mem_read),
    .mem_rd       (mem_rd),
    .stall        (stall)
  );

  // Sign-extended word offset, truncated so the add wraps modulo 2^ADDR_W.
  assign branch_address = id_pc_plus4 + ADDR_W'({{ADDR_W{imm[15]}}, imm, 2'b00});
  assign jump_address   = {id_instr[ADDR_W-3:0], 2'b00};

  assign pc_en        = !stall;
  assign id_bubble    = stall || !id_valid;
  assign branch_taken = id_valid && !stall && (op == OP_BEQ) && (rs_data == rt_data);
  assign jump         = id_valid && !stall && (op == OP_J);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_instr    <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
    end else if (!stall) begin
      if (branch_taken || jump) begin
        id_instr    <= '0;
        id_pc_plus4 <= '0;
        id_valid    <= 1'b0;
      end else begin
        id_instr    <= if_instr;
        id_pc_plus4 <= if_pc_plus4;
        id_valid    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_id_fetch_return.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor pops and compares.
module tb_id_fetch_return;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  if_pc_plus4;
  logic [31:0] if_instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        ex_mem_read;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;
  logic        mem_mem_read;
  logic [4:0]  mem_rd;
  logic        pc_en;
  logic        branch_taken;
  logic [9:0]  branch_address;
  logic        jump;
  logic [9:0]  jump_address;
  logic [31:0] id_instr;
  logic [9:0]  id_pc_plus4;
  logic        id_valid;
  logic        id_bubble;

  id_fetch_return #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .ex_mem_read    (ex_mem_read),
    .ex_reg_write   (ex_reg_write),
    .ex_rd          (ex_rd),
    .mem_mem_read   (mem_mem_read),
    .mem_rd         (mem_rd),
    .pc_en          (pc_en),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .jump           (jump),
    .jump_address   (jump_address),
    .id_instr       (id_instr),
    .id_pc_plus4    (id_pc_plus4),
    .id_valid       (id_valid),
    .id_bubble      (id_bubble)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc_en;
    logic        bt;
    logic        jmp;
    logic        bubble;
    logic        valid;
    logic [31:0] instr;
    logic [9:0]  pc4;
    logic [9:0]  br;
    logic [9:0]  ja;
  } outs_t;

  typedef struct {
    string name;
    outs_t v;
    outs_t m;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  localparam logic [31:0] ADDI = 32'h20080005;
  localparam logic [31:0] BEQ  = 32'h11090003;
  localparam logic [31:0] JMP  = 32'h08000040;
  localparam logic [31:0] ADD  = 32'h01095020;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic [31:0] ins, input logic [9:0] p4,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic exm, input logic exw, input logic [4:0] exr,
                       input logic mm, input logic [4:0] mr);
    reset        = rst;
    if_instr     = ins;
    if_pc_plus4  = p4;
    rs_data      = rsd;
    rt_data      = rtd;
    ex_mem_read  = exm;
    ex_reg_write = exw;
    ex_rd        = exr;
    mem_mem_read = mm;
    mem_rd       = mr;
  endtask

  task automatic expect_out(input string nm, input logic pe, input logic bt, input logic jm,
                            input logic bb, input logic vl, input logic [31:0] ins,
                            input logic [9:0] p4, input logic cb, input logic [9:0] ba,
                            input logic cj, input logic [9:0] ja);
    exp_t e;
    e.name     = nm;
    e.v.pc_en  = pe;
    e.v.bt     = bt;
    e.v.jmp    = jm;
    e.v.bubble = bb;
    e.v.valid  = vl;
    e.v.instr  = ins;
    e.v.pc4    = p4;
    e.v.br     = ba;
    e.v.ja     = ja;
    e.m        = '1;
    if (!cb) e.m.br = '0;
    if (!cj) e.m.ja = '0;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t  e;
    outs_t got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {pc_en, branch_taken, jump, id_bubble, id_valid,
               id_instr, id_pc_plus4, branch_address, jump_address};
        tests++;
        if (((got ^ e.v) & e.m) != '0) begin
          failed++;
          $display("FAIL %s: got pc_en=%0b bt=%0b j=%0b bub=%0b vld=%0b instr=%h pc4=%h br=%h ja=%h | want pc_en=%0b bt=%0b j=%0b bub=%0b vld=%0b instr=%h pc4=%h br=%h ja=%h",
                   e.name, got.pc_en, got.bt, got.jmp, got.bubble, got.valid, got.instr,
                   got.pc4, got.br, got.ja, e.v.pc_en, e.v.bt, e.v.jmp, e.v.bubble,
                   e.v.valid, e.v.instr, e.v.pc4, e.v.br, e.v.ja);
        end
      end
    end
  end

  initial begin : stimulus
    drive(0, 32'h0, 10'h0, 0, 0, 0, 0, 0, 0, 0);

    tick(); drive(0, ADDI, 10'h004, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset", 1, 0, 0, 1, 0, 32'h0, 10'h000, 1, 10'h000, 1, 10'h000);
    tick(); drive(1, ADDI, 10'h004, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset_hold", 1, 0, 0, 1, 0, 32'h0, 10'h000, 1, 10'h000, 1, 10'h000);
    tick(); drive(1, BEQ, 10'h010, 0, 0, 0, 0, 0, 0, 0);
    expect_out("straight", 1, 0, 0, 0, 1, ADDI, 10'h004, 1, 10'h018, 1, 10'h014);
    tick(); drive(1, 32'hDEADBEEF, 10'h014, 7, 7, 0, 0, 0, 0, 0);
    expect_out("beq_taken", 1, 1, 0, 0, 1, BEQ, 10'h010, 1, 10'h01C, 1, 10'h00C);
    tick(); drive(1, BEQ, 10'h020, 7, 7, 0, 0, 0, 0, 0);
    expect_out("beq_flush", 1, 0, 0, 1, 0, 32'h0, 10'h000, 1, 10'h000, 1, 10'h000);
    tick(); drive(1, JMP, 10'h024, 7, 8, 0, 0, 0, 0, 0);
    expect_out("beq_not_taken", 1, 0, 0, 0, 1, BEQ, 10'h020, 1, 10'h02C, 1, 10'h00C);
    tick(); drive(1, 32'hBADBAD00, 10'h028, 0, 0, 0, 0, 0, 0, 0);
    expect_out("jump", 1, 0, 1, 0, 1, JMP, 10'h024, 1, 10'h124, 1, 10'h100);
    tick(); drive(1, ADD, 10'h030, 0, 0, 0, 0, 0, 0, 0);
    expect_out("jump_flush", 1, 0, 0, 1, 0, 32'h0, 10'h000, 1, 10'h000, 1, 10'h000);
    tick(); drive(1, 32'h22220000, 10'h034, 0, 0, 1, 1, 8, 0, 0);
    expect_out("load_use_stall", 0, 0, 0, 1, 1, ADD, 10'h030, 0, 10'h0, 0, 10'h0);
    tick(); drive(1, 32'h22220000, 10'h034, 0, 0, 0, 0, 0, 1, 8);
    expect_out("load_use_release", 1, 0, 0, 0, 1, ADD, 10'h030, 0, 10'h0, 0, 10'h0);
    tick(); drive(1, BEQ, 10'h040, 0, 0, 0, 0, 0, 0, 0);
    expect_out("after_stall", 1, 0, 0, 0, 1, 32'h22220000, 10'h034, 0, 10'h0, 0, 10'h0);
    tick(); drive(1, 32'h33330000, 10'h044, 5, 5, 1, 1, 9, 0, 0);
    expect_out("beq_lw_ex", 0, 0, 0, 1, 1, BEQ, 10'h040, 0, 10'h0, 0, 10'h0);
    tick(); drive(1, 32'h33330000, 10'h044, 5, 5, 0, 0, 0, 1, 9);
    expect_out("beq_lw_mem", 0, 0, 0, 1, 1, BEQ, 10'h040, 0, 10'h0, 0, 10'h0);
    tick(); drive(1, 32'h33330000, 10'h044, 5, 5, 0, 0, 0, 0, 0);
    expect_out("beq_lw_resolve", 1, 1, 0, 0, 1, BEQ, 10'h040, 1, 10'h04C, 0, 10'h0);
    tick(); drive(1, ADD, 10'h050, 0, 0, 0, 0, 0, 0, 0);
    expect_out("beq_lw_flush", 1, 0, 0, 1, 0, 32'h0, 10'h000, 0, 10'h0, 0, 10'h0);
    tick(); drive(1, ADDI, 10'h054, 0, 0, 1, 1, 9, 0, 0);
    expect_out("load_use_rt", 0, 0, 0, 1, 1, ADD, 10'h050, 0, 10'h0, 0, 10'h0);
    tick(); drive(0, ADDI, 10'h060, 0, 0, 1, 1, 9, 0, 0);
    expect_out("reset_mid_stall", 1, 0, 0, 1, 0, 32'h0, 10'h000, 1, 10'h000, 1, 10'h000);
    tick(); drive(1, ADDI, 10'h060, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset_release", 1, 0, 0, 1, 0, 32'h0, 10'h000, 1, 10'h000, 1, 10'h000);
    tick(); drive(1, BEQ, 10'h070, 0, 0, 0, 0, 0, 0, 0);
    expect_out("first_after_reset", 1, 0, 0, 0, 1, ADDI, 10'h060, 0, 10'h0, 0, 10'h0);
    tick(); drive(1, 32'h44440000, 10'h074, 1, 1, 0, 1, 8, 0, 0);
    expect_out("beq_alu_ex", 0, 0, 0, 1, 1, BEQ, 10'h070, 0, 10'h0, 0, 10'h0);
    tick(); drive(1, 32'h44440000, 10'h074, 1, 1, 0, 0, 0, 0, 0);
    expect_out("beq_alu_resolve", 1, 1, 0, 0, 1, BEQ, 10'h070, 1, 10'h07C, 0, 10'h0);
    tick(); drive(1, 32'h11000003, 10'h080, 0, 0, 0, 0, 0, 0, 0);
    expect_out("beq_alu_flush", 1, 0, 0, 1, 0, 32'h0, 10'h000, 0, 10'h0, 0, 10'h0);
    tick(); drive(1, 32'h1000FFFC, 10'h004, 3, 4, 0, 1, 0, 1, 0);
    expect_out("rd_zero_no_stall", 1, 0, 0, 0, 1, 32'h11000003, 10'h080, 1, 10'h08C, 0, 10'h0);
    tick(); drive(1, 32'h0, 10'h088, 0, 0, 0, 0, 0, 0, 0);
    expect_out("beq_neg_wrap", 1, 1, 0, 0, 1, 32'h1000FFFC, 10'h004, 1, 10'h3F4, 0, 10'h0);
    tick(); drive(1, 32'h0, 10'h08C, 0, 0, 0, 0, 0, 0, 0);
    expect_out("neg_flush", 1, 0, 0, 1, 0, 32'h0, 10'h000, 0, 10'h0, 0, 10'h0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/id_fetch_return.md
# id_fetch_return

Decode-side partner of the instruction fetch stage: it holds the IF/ID pipeline register, decides whether the fetch stage advances, and drives the redirect signals back to fetch. It resolves `beq` and `j` in ID, computes the 10-bit targets, flushes the wrong-path instruction, and stalls on load-use and branch-operand hazards. It sits between the fetch stage and the ID/EX register, next to the register file.

## Interface

Parameters:
- `ADDR_W`, default 10: PC and instruction-address width.
- `DATA_W`, default 32: instruction and register-data width.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low.
- `if_pc_plus4`  in  ADDR_W  PC+4 from fetch.
- `if_instr`  in  DATA_W  instruction from fetch.
- `rs_data`  in  DATA_W  register-file read of `id_instr[25:21]`.
- `rt_data`  in  DATA_W  register-file read of `id_instr[20:16]`.
- `ex_mem_read`  in  1  instruction in EX is `lw`.
- `ex_reg_write`  in  1  instruction in EX writes a register.
- `ex_rd`  in  5  EX destination register.
- `mem_mem_read`  in  1  instruction in MEM is `lw`.
- `mem_rd`  in  5  MEM destination register.
- `pc_en`  out  1  fetch PC/IF-ID advance enable.
- `branch_taken`  out  1  redirect to `branch_address`.
- `branch_address`  out  ADDR_W  branch target.
- `jump`  out  1  redirect to `jump_address`.
- `jump_address`  out  ADDR_W  jump target.
- `id_instr`  out  DATA_W  registered instruction.
- `id_pc_plus4`  out  ADDR_W  registered PC+4.
- `id_valid`  out  1  `id_instr` is a real instruction.
- `id_bubble`  out  1  the ID/EX register loads zeroed control this cycle.

## Operation

- Decode fields: `op=id_instr[31:26]`, `rs=[25:21]`, `rt=[20:16]`, `imm=[15:0]`, `target=[25:0]`.
- Recognised opcodes: `beq` = 6'h04, `j` = 6'h02. Every other opcode is non-control.
- `branch_address = id_pc_plus4 + (sign_extend(imm) << 2)`, truncated to ADDR_W and wrapping modulo 2^ADDR_W.
- `jump_address = {target[ADDR_W-3:0], 2'b00}`.
- `rs_src` is 1 for every opcode except `j`. `rt_src` is 1 for R-type (op 0) and `beq` only.
- Hazard conditions:
  - Load-use: `ex_mem_read && ex_rd!=0 && ((rs_src && ex_rd==rs) || (rt_src && ex_rd==rt))`.
  - Branch-EX: `op==beq && ex_reg_write && ex_rd!=0 && ex_rd∈{rs,rt}`.
  - Branch-MEM: `op==beq && mem_mem_read && mem_rd!=0 && mem_rd∈{rs,rt}`.
- `stall = id_valid && (load-use || branch-EX || branch-MEM)`.
- `pc_en = !stall`. `id_bubble = stall || !id_valid`.
- `branch_taken = id_valid && !stall && op==beq && rs_data==rt_data`.
- `jump = id_valid && !stall && op==j`. When `jump` is 1, `branch_taken` is 0.
- IF/ID register update on each `posedge clk`:
  - If `stall`: hold all three fields.
  - Else if `branch_taken || jump`: flush to `id_instr=0`, `id_pc_plus4=0`, `id_valid=0`.
  - Else: load `if_instr`, `if_pc_plus4`, and `id_valid=1`.
- Stall takes priority over redirect. A `beq` waiting on an operand does not redirect until its operands are final.

## Timing

- Reset (`reset`=0, asynchronous): `id_instr=0`, `id_pc_plus4=0`, `id_valid=0`. Consequently `pc_en=1`, `branch_taken=0`, `jump=0`, `id_bubble=1`.
- Reset asserted mid-stall or mid-redirect clears the register immediately. Outputs follow within the same cycle with no further edge needed.
- Fetch-to-ID latency: 1 cycle.
- Redirect is combinational in the ID cycle. The PC loads the target and the wrong-path fetch is flushed at the same edge. Penalty: 1 bubble.
- Load-use: 1 stall cycle.
- `beq` after an ALU producer: 1 stall cycle.
- `beq` after a `lw` producer: 2 stall cycles (EX, then MEM).
- All outputs except the IF/ID register are combinational from the register and the inputs. There are no outputs with combinational paths from `if_*` inputs.

## Structure

- Shared package holds the opcode constants (`OP_RTYPE`, `OP_BEQ`, `OP_J`, `OP_LW`) and the field-position constants.
- One natural sub-module, `hazard_detect`, which is purely combinational and produces `stall` from the decoded fields and the EX/MEM inputs.
- The IF/ID register and the target arithmetic stay in the top module.

## Test plan

- Straight line: `if_instr=0x20080005`, `if_pc_plus4=0x004` -> after the edge, `id_instr=0x20080005`, `id_pc_plus4=0x004`, `id_valid=1`, `pc_en=1`, `id_bubble=0`.
- `beq` taken: `id_instr=0x11090003`, `id_pc_plus4=0x010`, `rs_data=rt_data=7` -> `branch_taken=1`, `branch_address=0x01C`; next edge gives `id_valid=0`. With `rt_data=8` -> `branch_taken=0`.
- Jump: `id_instr=0x08000040` -> `jump=1`, `jump_address=0x100`, `branch_taken=0`; the next cycle is a bubble.
- Load-use: `id_instr=0x01095020`, `ex_mem_read=1`, `ex_rd=8` -> `pc_en=0`, `id_bubble=1`, IF/ID held for exactly one cycle, then normal flow resumes.
- `beq` after `lw`: `id_instr=0x11090003`, `lw` to $9 in EX -> 2 stall cycles. During the stall, `branch_taken=0` even with equal operands. The branch resolves on the third cycle.
- Reset low during a stall -> `id_valid=0`, `pc_en=1` immediately. After release, the first fetched instruction loads at the next edge.
